// File: rtl/jk_drive_pkg.sv
// jk_drive_pkg: shared definitions for the JK pattern driver.
//   state_t : controller states (IDLE, RUN, CHK), 2-bit encoding.
//   jk_exc  : J/K excitation for one bit, given its present value p, its
//             target value t, and the don't-care resolution tgl.
package jk_drive_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CHK  = 2'd2
  } state_t;

  // Returns {j, k}. For each bit, the only input that matters is the one
  // that moves it the right way. The other input is a don't-care, and tgl
  // resolves it: 0 gives hold/set/reset, 1 gives toggle.
  function automatic logic [1:0] jk_exc(input logic p, input logic t, input logic tgl);
    logic [1:0] jk;
    if (!p) jk = {t, tgl};    // 0->t : J carries the target
    else    jk = {tgl, ~t};   // 1->t : K carries the inverted target
    return jk;
  endfunction

endpackage

// File: rtl/jk_excite.sv
// jk_excite: N-bit combinational J/K excitation for a JK flop bank.
// Ports:
//   en   in  1  drive enable; j/k are forced to zero when low
//   tgl  in  1  don't-care resolution (0 = hold/set/reset, 1 = toggle)
//   q    in  N  present state of the bank
//   tgt  in  N  target state
//   j    out N  J excitation
//   k    out N  K excitation
module jk_excite
  import jk_drive_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         en,
  input  logic         tgl,
  input  logic [N-1:0] q,
  input  logic [N-1:0] tgt,
  output logic [N-1:0] j,
  output logic [N-1:0] k
);

  always_comb begin
    // NOTE: give every output a default first so that no path through the
    // block leaves a value unassigned, which would infer a latch.
    j = '0;
    k = '0;
    if (en) begin
      for (int i = 0; i < N; i++) begin
        {j[i], k[i]} = jk_exc(q[i], tgt[i], tgl);
      end
    end
  end

endmodule

// File: rtl/jk_drive.sv
// jk_drive: pattern driver and checker for a bank of JK flip-flops.
// The block plays a programmed sequence of target states. Each RUN cycle it
// produces the J/K excitation that moves the bank from q to the current
// target. In the following cycle it compares q with that target.
// Ports:
//   c          in  1  clock, rising edge
//   rst_n      in  1  synchronous active-low reset
//   load       in  1  append load_data to the pattern memory (IDLE only)
//   load_data  in  N  target state to append
//   clr        in  1  empty the pattern memory and clear err/err_bit (IDLE only)
//   start      in  1  begin playback (IDLE only, ignored when empty)
//   stop       in  1  end playback after the current step
//   loop       in  1  latched at start: wrap instead of finishing
//   tgl        in  1  latched at start: don't-care resolution
//   q          in  N  present state fed back from the JK bank
//   j, k       out N  J/K excitation (zero outside RUN)
//   busy       out 1  in RUN or CHK
//   done       out 1  one-cycle pulse in CHK
//   full       out 1  pattern memory full
//   err        out 1  sticky mismatch flag
//   err_bit    out N  sticky OR of mismatching bit positions
module jk_drive
  import jk_drive_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = 8
) (
  input  logic         c,
  input  logic         rst_n,
  input  logic         load,
  input  logic [N-1:0] load_data,
  input  logic         clr,
  input  logic         start,
  input  logic         stop,
  input  logic         loop,
  input  logic         tgl,
  input  logic [N-1:0] q,
  output logic [N-1:0] j,
  output logic [N-1:0] k,
  output logic         busy,
  output logic         done,
  output logic         full,
  output logic         err,
  output logic [N-1:0] err_bit
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]   IDX_ONE  = AW'(1);

  state_t         state, state_nxt;
  logic [N-1:0]   mem [DEPTH];
  logic [AW:0]    cnt;
  logic [AW-1:0]  idx;
  logic           loop_r, tgl_r;
  logic [N-1:0]   exp_q;
  logic           chk;

  logic [N-1:0]   tgt;
  logic           last;
  logic           start_ok;
  logic           wr_en;

  assign tgt      = mem[idx];
  assign last     = ({1'b0, idx} == (cnt - CNT_ONE));
  assign full     = (cnt == CNT_FULL);
  assign busy     = (state != IDLE);
  assign done     = (state == CHK);
  // clr outranks start, and start outranks load in the same IDLE cycle.
  assign start_ok = (state == IDLE) && start && !clr && (cnt != '0);
  assign wr_en    = rst_n && (state == IDLE) && load && !clr && !start && !full;

  always_ff @(posedge c) begin
    // NOTE: sequential state uses non-blocking assignments, so every
    // register samples values from before the edge. This avoids ordering races.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = RUN;
      RUN:     if (stop || (last && !loop_r)) state_nxt = CHK;
      CHK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the pattern memory has no reset. Its contents only become
  // meaningful through cnt, and leaving it unreset keeps it a plain register
  // array with no reset fan-out.
  always_ff @(posedge c) begin
    if (wr_en) mem[cnt[AW-1:0]] <= load_data;
  end

  always_ff @(posedge c) begin
    if (!rst_n) begin
      cnt     <= '0;
      idx     <= '0;
      loop_r  <= 1'b0;
      tgl_r   <= 1'b0;
      exp_q   <= '0;
      chk     <= 1'b0;
      err     <= 1'b0;
      err_bit <= '0;
    end else begin
      // The bank responded on the edge that ended the previous drive cycle.
      // exp_q holds the target of that cycle.
      if (chk && (q != exp_q)) begin
        err     <= 1'b1;
        err_bit <= err_bit | (q ^ exp_q);
      end
      case (state)
        IDLE: begin
          if (clr) begin
            cnt     <= '0;
            err     <= 1'b0;
            err_bit <= '0;
          end else if (start_ok) begin
            loop_r  <= loop;
            tgl_r   <= tgl;
            idx     <= '0;
            err     <= 1'b0;
            err_bit <= '0;
          end else if (wr_en) begin
            cnt <= cnt + CNT_ONE;
          end
        end
        RUN: begin
          exp_q <= tgt;
          chk   <= 1'b1;
          if (last) idx <= '0;
          else      idx <= idx + IDX_ONE;
        end
        default: chk <= 1'b0;  // CHK: its compare is the last one
      endcase
    end
  end

  jk_excite #(.N(N)) u_excite (
    .en  (state == RUN),
    .tgl (tgl_r),
    .q   (q),
    .tgt (tgt),
    .j   (j),
    .k   (k)
  );

endmodule

// File: doc/jk_drive.md
# jk_drive

Pattern driver and checker for a bank of JK flip-flops: the inverse of the `jk` cell. It holds a programmed sequence of target states and computes the J/K excitation each cycle that moves the flop bank from its present state `q` to the next target. It then checks the flop's response against the expected state. It sits next to a `jk` bank as an on-chip stimulus and self-check engine, and is the synthesizable counterpart of our JK flip-flop stimulus benches.

## Interface
Parameters:
- `N`, 4: width of the JK bank driven, in bits.
- `DEPTH`, 8: pattern memory entries; power of two, at least 2.

Ports:
- `c`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset: synchronous and active-low.
- `load`  in  1  write `load_data` into the pattern memory (IDLE only).
- `load_data`  in  N  target state to append.
- `clr`  in  1  IDLE only: empty the pattern memory and clear `err`/`err_bit`.
- `start`  in  1  begin sequence playback (IDLE only; ignored when `cnt`=0).
- `stop`  in  1  end loop playback early.
- `loop`  in  1  sampled at `start`: wrap the index from `cnt`-1 to 0 instead of finishing.
- `tgl`  in  1  sampled at `start`: don't-care resolution (0 = hold/set/reset only, 1 = prefer toggle).
- `q`  in  N  present state fed back from the JK bank.
- `j`  out  N  J excitation.
- `k`  out  N  K excitation.
- `busy`  out  1  in RUN or CHK.
- `done`  out  1  one-cycle pulse in CHK.
- `full`  out  1  `cnt`==DEPTH.
- `err`  out  1  sticky mismatch flag.
- `err_bit`  out  N  sticky OR of mismatching bit positions.

## Operation
- Reset (`rst_n`=0 at an edge):
  - Resets to IDLE with `cnt`=0 and `idx`=0.
  - `err`=0, `err_bit`=0, `done`=0, `busy`=0, `full`=0.
  - `j`=`k`=0, and `chk`=0.
  - Pattern memory contents are not reset.
- IDLE:
  - `j`=`k`=0, so the bank holds.
  - `load` writes `mem[cnt]` and increments `cnt`; a `load` while `full` is ignored.
  - `clr` has priority over `load` and `start`.
  - `start` with `cnt`>0 latches `loop`/`tgl`, sets `idx`=0, goes to RUN, and clears `err`/`err_bit`.
- RUN: `j`/`k` are combinational from `q` and `mem[idx]`, bit by bit. Per bit (present→target):
  - 0→0: `j`=0, `k`=`tgl`.
  - 0→1: `j`=1, `k`=`tgl`.
  - 1→0: `j`=`tgl`, `k`=1.
  - 1→1: `j`=`tgl`, `k`=0.
- At each RUN edge:
  - `exp`<=`mem[idx]` and `chk`<=1.
  - If `idx`==`cnt`-1: with `loop`=0, go to CHK; otherwise set `idx`<=0.
  - Otherwise `idx`<=`idx`+1.
  - `stop` in RUN: go to CHK after the current step; `stop` has priority over wrap.
- CHK: one cycle; `j`=`k`=0, `done`=1, then IDLE.
- Check, every cycle with `chk`=1:
  - If `q`!=`exp`: `err`<=1 and `err_bit`<=`err_bit`|(`q`^`exp`).
  - `chk` clears on entering IDLE.
- `load`, `clr` and `start` in RUN/CHK are ignored.

## Timing
- `start` edge → first drive cycle follows; drive is zero-latency combinational from `q`.
- The flop updates on the edge ending a drive cycle, and is compared in the following cycle.
- A pattern of length L with `loop`=0 takes L RUN cycles plus 1 CHK cycle; `done` is in cycle L+1 after `start`; `busy` is high for L+1 cycles.
- The last compare happens in CHK.
- `err` is visible one cycle after the mismatching compare cycle.
- Reset mid-RUN: outputs return to their reset values in the cycle after the edge, with no `done` pulse.

## Structure
- Package `jk_drive_pkg`:
  - State encoding constants IDLE, RUN, CHK (2-bit).
  - Function `jk_exc(p, t, tgl)` returning {j,k} for one bit.
- Sub-module `jk_excite` (N-bit combinational excitation, wrapping `jk_exc`). It is instantiated once and gated to zero outside RUN.
- Pattern memory is a register array; `cnt` is `$clog2(DEPTH)+1` bits and `idx` is `$clog2(DEPTH)` bits.

## Test plan
- Reset: hold `rst_n`=0 for 2 edges → `j`=`k`=0, `busy`=`done`=`err`=`full`=0, `err_bit`=0.
- Load 1,3,0,F; `start` with `tgl`=0, ideal `jk` model, `q`=0. Expected RUN cycles:
  - cycle 1: `j`=0001, `k`=0000.
  - cycle 2: `j`=0010, `k`=0000.
  - cycle 3: `j`=0000, `k`=0011.
  - cycle 4: `j`=1111, `k`=0000.
  - `done` in cycle 5, `err`=0.
- Same pattern with `tgl`=1 → cycle 1 gives `j`=0001, `k`=1111, and `q` sequence 1,3,0,F is reached. Compare the final `q` with the `tgl`=0 run: it must be identical, with `err`=0.
- Fault: model bit2 stuck at 0, pattern 4,4 → `err`=1 and `err_bit`=0100 one cycle after the first compare cycle; both remain set after `done`.
- Load 9 words → `full`=1 after the 8th and the 9th is dropped. Then `loop`=1 `start`: `idx` wraps 7→0 repeatedly. `stop` → CHK, `done`, IDLE.
- Reset at RUN cycle 2 → next cycle `busy`=0, `j`=`k`=0, `cnt`=0, with no `done` pulse.
